spike_packet_sink: RTL and testbench

Receiving end of the router local-port spike interface. It accepts spike packets that the boundary router pushes out of its local port using the write_enable/receive_full handshake. Each packet is tagged with the current time-step index and buffered in a FIFO. Packets are then presented to the host/controller side on a valid/ready stream. The block sits between the boundary router local output and the mesh controller or testbench monitor, all in the router clock domain.

---
 rtl/spike_packet_sink_pkg.sv | 19 +
 rtl/spike_sync_fifo.sv | 60 ++++++
 rtl/spike_packet_sink.sv | 97 +++++++++
 tb/tb_spike_packet_sink.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spike_packet_sink_pkg.sv
// Shared definitions for the spike sink, router and controller: default widths,
// packet field layout and time-step defaults.
package spike_packet_sink_pkg;
    localparam int PKT_WIDTH_DEF   = 4;
    localparam int STEP_BITS_DEF   = 5;
    localparam int DEST_BITS       = 2;
    localparam int AXON_BITS       = PKT_WIDTH_DEF - DEST_BITS;
    localparam int STEP_NUMBER_DEF = 32;
    localparam int STEP_CYCLE_DEF  = 64;

    typedef struct packed {
        logic [DEST_BITS-1:0] dest;
        logic [AXON_BITS-1:0] axon;
    } spike_pkt_t;

    function automatic logic [DEST_BITS-1:0] pkt_dest(input spike_pkt_t p);
        return p.dest;
    endfunction
endpackage

// File: rtl/spike_sync_fifo.sv
// Generic show-ahead synchronous FIFO; almost_full flags the level the FIFO
// will hold after the current cycle's push/pop.
module spike_sync_fifo #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 8,
    parameter int ADDR_BITS   = 3,
    parameter int FULL_MARGIN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [ADDR_BITS:0]   count,
    output logic                 almost_full,
    output logic                 full
);
    localparam logic [ADDR_BITS:0] FULL_LVL = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AF_LVL   = (ADDR_BITS+1)'(DEPTH - FULL_MARGIN);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 push_ok, pop_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != FULL_LVL) || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign dout        = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = (count_d >= AF_LVL);
    assign full        = (count_q == FULL_LVL);
endmodule

// File: rtl/spike_packet_sink.sv
// Router local-port spike sink: step counter, packet tagging, overflow counting
// and registered back-pressure. Define SPIKE_SINK_STEP_TAG_EN to store step tags.
module spike_packet_sink
    import spike_packet_sink_pkg::*;
#(
    parameter int PKT_WIDTH   = PKT_WIDTH_DEF,
    parameter int DEPTH       = 8,
    parameter int ADDR_BITS   = 3,
    parameter int FULL_MARGIN = 1,
    parameter int STEP_BITS   = STEP_BITS_DEF,
    parameter int DROP_BITS   = 8
) (
    input  logic                 rt_clk,
    input  logic                 rt_reset,
    input  logic                 step_pulse,
    input  logic [PKT_WIDTH-1:0] packet_in,
    input  logic                 write_enable,
    output logic                 receive_full,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PKT_WIDTH-1:0] out_packet,
    output logic [STEP_BITS-1:0] out_step,
    output logic [DROP_BITS-1:0] drop_cnt,
    output logic [STEP_BITS-1:0] step_idx
);
`ifdef SPIKE_SINK_STEP_TAG_EN
    localparam int FW = PKT_WIDTH + STEP_BITS;
`else
    localparam int FW = PKT_WIDTH;
`endif

    logic [STEP_BITS-1:0] step_idx_q, step_idx_d;
    logic [DROP_BITS-1:0] drop_cnt_q, drop_cnt_d;
    logic                 receive_full_q;
    logic [FW-1:0]        fifo_din, fifo_dout;
    logic [ADDR_BITS:0]   fifo_count;
    logic                 fifo_af, fifo_full;
    logic                 push, pop, drop;

    assign pop  = out_valid && out_ready;
    assign push = write_enable && (!fifo_full || pop);
    assign drop = write_enable && fifo_full && !pop;

`ifdef SPIKE_SINK_STEP_TAG_EN
    // Tag with the pre-increment step index, so a write on step_pulse stays in the old step.
    assign fifo_din   = {step_idx_q, packet_in};
    assign out_packet = fifo_dout[PKT_WIDTH-1:0];
    assign out_step   = fifo_dout[FW-1:PKT_WIDTH];
`else
    assign fifo_din   = packet_in;
    assign out_packet = fifo_dout;
    assign out_step   = '0;
`endif

    spike_sync_fifo #(
        .WIDTH      (FW),
        .DEPTH      (DEPTH),
        .ADDR_BITS  (ADDR_BITS),
        .FULL_MARGIN(FULL_MARGIN)
    ) u_fifo (
        .clk        (rt_clk),
        .rst        (rt_reset),
        .push       (push),
        .pop        (pop),
        .din        (fifo_din),
        .dout       (fifo_dout),
        .count      (fifo_count),
        .almost_full(fifo_af),
        .full       (fifo_full)
    );

    always_comb begin
        step_idx_d = step_idx_q;
        drop_cnt_d = drop_cnt_q;
        if (step_pulse)
            step_idx_d = step_idx_q + 1'b1;
        if (drop && (drop_cnt_q != {DROP_BITS{1'b1}}))
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge rt_clk) begin
        if (rt_reset) begin
            step_idx_q     <= '0;
            drop_cnt_q     <= '0;
            receive_full_q <= 1'b0;
        end else begin
            step_idx_q     <= step_idx_d;
            drop_cnt_q     <= drop_cnt_d;
            receive_full_q <= fifo_af;
        end
    end

    assign out_valid    = (fifo_count != '0);
    assign receive_full = receive_full_q;
    assign drop_cnt     = drop_cnt_q;
    assign step_idx     = step_idx_q;
endmodule

// File: tb/tb_spike_packet_sink.sv
// Directed bench for spike_packet_sink: vector table plus hand-written
// back-pressure, wrap, saturation and reset sequences.
module tb_spike_packet_sink;
    logic       rt_clk = 1'b0;
    logic       rt_reset, step_pulse, write_enable, out_ready;
    logic [3:0] packet_in;
    logic       receive_full, out_valid;
    logic [3:0] out_packet;
    logic [4:0] out_step, step_idx;
    logic [7:0] drop_cnt;

    int n_total = 0;
    int n_pass  = 0;

    spike_packet_sink dut (
        .rt_clk      (rt_clk),
        .rt_reset    (rt_reset),
        .step_pulse  (step_pulse),
        .packet_in   (packet_in),
        .write_enable(write_enable),
        .receive_full(receive_full),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_packet  (out_packet),
        .out_step    (out_step),
        .drop_cnt    (drop_cnt),
        .step_idx    (step_idx)
    );

    always #5 rt_clk = ~rt_clk;

    typedef struct {
        logic       sp;
        logic       we;
        logic [3:0] pkt;
        logic       rdy;
        logic       ev;
        logic [3:0] epkt;
        int         etag;
        int         eidx;
    } vec_t;

    vec_t vecs [9];

    function automatic int etag(input int t);
`ifdef SPIKE_SINK_STEP_TAG_EN
        return t;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic sp, input logic we, input logic [3:0] pkt, input logic rdy);
        step_pulse   = sp;
        write_enable = we;
        packet_in    = pkt;
        out_ready    = rdy;
    endtask

    task automatic tick();
        @(posedge rt_clk);
        #1;
    endtask

    task automatic chk_head(input string name, input int pkt, input int tag);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_pkt"}, int'(out_packet), pkt);
        chk({name, "_tag"}, int'(out_step), etag(tag));
    endtask

    initial begin
        rt_reset = 1'b1;
        drive(0, 0, 4'h0, 0);
        tick(); tick();
        rt_reset = 1'b0;

        // Reset release, idle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", int'(out_valid), 0);
            chk("idle_full", int'(receive_full), 0);
            chk("idle_drop", int'(drop_cnt), 0);
            chk("idle_idx", int'(step_idx), 0);
            if (i == 0) begin
                chk("idle_pkt", int'(out_packet), 0);
                chk("idle_tag", int'(out_step), 0);
            end
        end
        drive(1, 0, 4'h0, 0);
        tick(); tick(); tick();
        drive(0, 0, 4'h0, 0);
        tick();
        chk("three_pulses_idx", int'(step_idx), 3);
        rt_reset = 1'b1;
        tick();
        rt_reset = 1'b0;
        chk("reset_idx", int'(step_idx), 0);

        //            sp we pkt   rdy ev epkt  tag idx
        vecs[0] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 0, 1};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 0, 2};
        vecs[2] = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 4'hA, 2, 2};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 0, 2};
        vecs[4] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 4'h3, 2, 3};
        vecs[5] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 4'h3, 2, 3};
        vecs[6] = '{1'b0, 1'b1, 4'h6, 1'b1, 1'b1, 4'h5, 3, 3};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h6, 3, 3};
        vecs[8] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 0, 3};
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].sp, vecs[v].we, vecs[v].pkt, vecs[v].rdy);
            tick();
            chk($sformatf("vec%0d_valid", v), int'(out_valid), int'(vecs[v].ev));
            chk($sformatf("vec%0d_idx", v), int'(step_idx), vecs[v].eidx);
            chk($sformatf("vec%0d_full", v), int'(receive_full), 0);
            chk($sformatf("vec%0d_drop", v), int'(drop_cnt), 0);
            if (vecs[v].ev) begin
                chk($sformatf("vec%0d_pkt", v), int'(out_packet), int'(vecs[v].epkt));
                chk($sformatf("vec%0d_tag", v), int'(out_step), etag(vecs[v].etag));
            end
        end

        // Back-pressure: 8 writes with consumer stalled
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 4'(i), 0);
            tick();
            chk($sformatf("bp_full_w%0d", i), int'(receive_full), (i >= 7) ? 1 : 0);
            chk_head("bp_head", 1, 3);
        end
        drive(0, 1, 4'h9, 0);
        tick();
        chk("overflow_drop", int'(drop_cnt), 1);
        chk("overflow_full", int'(receive_full), 1);
        chk_head("overflow_head", 1, 3);

        // Full FIFO: push and pop together is accepted
        drive(0, 1, 4'hF, 1);
        tick();
        chk("fullpp_drop", int'(drop_cnt), 1);
        chk("fullpp_full", int'(receive_full), 1);
        for (int j = 0; j < 8; j++) begin
            chk_head($sformatf("drain%0d", j), (j < 7) ? j + 2 : 15, 3);
            chk($sformatf("drain%0d_full", j), int'(receive_full), (j < 2) ? 1 : 0);
            drive(0, 0, 4'h0, 1);
            tick();
        end
        chk("drained_valid", int'(out_valid), 0);
        chk("drained_drop", int'(drop_cnt), 1);

        // Step wrap with coincident write
        drive(1, 0, 4'h0, 0);
        for (int i = 0; i < 28; i++) tick();
        chk("pre_wrap_idx", int'(step_idx), 31);
        drive(1, 1, 4'hC, 0);
        tick();
        chk("wrap_idx", int'(step_idx), 0);
        chk_head("wrap_head", 12, 31);
        drive(0, 1, 4'hD, 0);
        tick();
        chk_head("wrap_hold", 12, 31);
        drive(0, 0, 4'h0, 1);
        tick();
        chk_head("wrap_next", 13, 0);
        tick();
        chk("wrap_empty", int'(out_valid), 0);

        // Mid-operation reset with 5 buffered entries (drop_cnt still 1)
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 4'(i), 0);
            tick();
        end
        chk("prerst_valid", int'(out_valid), 1);
        chk("prerst_drop", int'(drop_cnt), 1);
        rt_reset = 1'b1;
        drive(1, 1, 4'h7, 0);
        tick();
        rt_reset = 1'b0;
        drive(0, 0, 4'h0, 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_full", int'(receive_full), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_idx", int'(step_idx), 0);
        chk("rst_pkt", int'(out_packet), 0);
        tick();
        chk("rst_inflight_ignored", int'(out_valid), 0);
        drive(0, 1, 4'h9, 0);
        tick();
        chk_head("postrst_head", 9, 0);
        drive(0, 0, 4'h0, 1);
        tick();
        chk("postrst_empty", int'(out_valid), 0);

        // Drop counter saturation
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 4'(i), 0);
            tick();
        end
        for (int i = 0; i < 300; i++) tick();
        chk("drop_sat", int'(drop_cnt), 255);
        chk_head("sat_head", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
